fft_radix4_bfly_stage: RTL

- Parametrised, fully pipelined radix-4 DIT butterfly stage for the streaming FFT datapath in the LSTM accelerator.
- Processes GROUPS independent 4-point complex butterflies per cycle.
- Adds a forward/inverse mode, per-sample 1/4 scaling with rounding, and a global stall enable.
- Frame strobe next_in travels alongside the data and emerges as next_out.

---
 rtl/fft_pkg.sv | 41 ++++
 rtl/fft_radix4_bfly_stage_if.sv | 36 +++
 rtl/fft_bfly_addsub.sv | 47 ++++
 rtl/fft_radix4_bfly_stage.sv | 118 +++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: constants and helpers shared by the streaming FFT butterfly stages.
//   FFT_BFLY_LAT  input-to-output latency of one radix-4 butterfly stage
//   FFT_RADIX     radix of the butterfly
//   cplx_idx      bit offset of the re/im slice of complex point k in a packed bus
//   round_sat     post-add rounding (scale) and optional saturation
package fft_pkg;

   localparam int FFT_BFLY_LAT = 3;
   localparam int FFT_RADIX    = 4;

   // Point k occupies two WIDTH-bit slices: real first, imaginary above it.
   function automatic int cplx_idx(input int k, input logic im, input int w);
      return (2 * k + (im ? 1 : 0)) * w;
   endfunction

   // sum is a sign-extended (w+1)-bit add/sub result. Returns a value whose
   // low w bits are the stage output.
   //   scale = 1 : (sum + 1) >>> 1, round half up; always fits in w bits.
   //   scale = 0 : sum itself, clamped to the w-bit range when sat = 1,
   //               otherwise the caller's truncation wraps it.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] sum,
                                                   input int unsigned       w,
                                                   input logic              scale,
                                                   input logic              sat);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      logic signed [63:0] r;
      max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (w - 1));
      if (scale)
         r = (sum + 64'sd1) >>> 1;
      else if (sat && (sum > max_v))
         r = max_v;
      else if (sat && (sum < min_v))
         r = min_v;
      else
         r = sum;
      return r;
   endfunction

endpackage

// File: rtl/fft_radix4_bfly_stage_if.sv
// fft_radix4_bfly_stage_if: streaming bus of the radix-4 butterfly stage.
//   en        pipeline advance (0 = every register holds)
//   next_in   frame-start strobe, aligned with first x_in word
//   inverse   0 = forward (-j twiddle), 1 = inverse (+j twiddle)
//   scale     1 = halve with rounding at each internal stage
//   x_in      NP packed complex points (re at 2k, im at 2k+1)
//   y_out     NP packed complex results, same packing
//   next_out  next_in delayed by the stage latency
// master drives the stimulus side, slave is the butterfly stage.
interface fft_radix4_bfly_stage_if #(
   parameter int WIDTH  = 18,
   parameter int GROUPS = 4
);
   import fft_pkg::*;

   localparam int NP = FFT_RADIX * GROUPS;

   logic                    en;
   logic                    next_in;
   logic                    inverse;
   logic                    scale;
   logic [2*NP*WIDTH-1:0]   x_in;
   logic [2*NP*WIDTH-1:0]   y_out;
   logic                    next_out;

   modport master (
      output en, next_in, inverse, scale, x_in,
      input  y_out, next_out
   );

   modport slave (
      input  en, next_in, inverse, scale, x_in,
      output y_out, next_out
   );

endinterface

// File: rtl/fft_bfly_addsub.sv
// fft_bfly_addsub: one registered WIDTH-bit add/sub lane.
//   clk, reset  clock, asynchronous active-high reset
//   en          register enable
//   sub         0 = a + b, 1 = a - b
//   scale       1 = halve the (WIDTH+1)-bit result with round half up
//   a, b        two's complement operands
//   q           registered result
// Build option FFT_BFLY_SATURATE_EN: unscaled results clamp instead of wrap.
module fft_bfly_addsub
   import fft_pkg::*;
#(
   parameter int WIDTH = 18
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    sub,
   input  logic                    scale,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] q
);

`ifdef FFT_BFLY_SATURATE_EN
   localparam logic SAT = 1'b1;
`else
   localparam logic SAT = 1'b0;
`endif

   logic signed [WIDTH:0]   sum;
   logic signed [WIDTH-1:0] q_next;

   always_comb begin
      // one guard bit so the true sum is always representable
      sum    = sub ? ({a[WIDTH-1], a} - {b[WIDTH-1], b})
                   : ({a[WIDTH-1], a} + {b[WIDTH-1], b});
      q_next = WIDTH'(round_sat(64'(sum), WIDTH, scale, SAT));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else if (en)
         q <= q_next;
   end

endmodule

// File: rtl/fft_radix4_bfly_stage.sv
// fft_radix4_bfly_stage: fully pipelined radix-4 DIT butterfly, GROUPS
// independent 4-point butterflies per cycle, latency 3 enabled edges.
//   clk, reset  clock, asynchronous active-high reset
//   bus         fft_radix4_bfly_stage_if.slave (en, next_in, inverse, scale,
//               x_in in; y_out, next_out out)
// Pipeline: R0 input register -> S1 (p0+-p2, p1+-p3) -> S2 (combine, twiddle).
// Build option FFT_BFLY_SATURATE_EN (in fft_bfly_addsub): clamp on overflow.
module fft_radix4_bfly_stage
   import fft_pkg::*;
#(
   parameter int WIDTH  = 18,
   parameter int GROUPS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   fft_radix4_bfly_stage_if.slave bus
);

   localparam int NP = FFT_RADIX * GROUPS;
   localparam int G  = GROUPS;

   logic [2*NP*WIDTH-1:0] x_r0;
   logic                  inv_r0, scale_r0, next_r0;
   logic                  inv_s1, scale_s1, next_s1;
   logic                  next_s2;

   logic signed [WIDTH-1:0] pt_re [NP];
   logic signed [WIDTH-1:0] pt_im [NP];
   logic signed [WIDTH-1:0] s_re  [4][G];
   logic signed [WIDTH-1:0] s_im  [4][G];
   logic signed [WIDTH-1:0] y_re  [NP];
   logic signed [WIDTH-1:0] y_im  [NP];
   logic [2*NP*WIDTH-1:0]   y_pack;

   // Control bits travel with their own sample so mode changes mid-stream
   // only affect later samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_r0     <= '0;
         inv_r0   <= 1'b0;
         scale_r0 <= 1'b0;
         next_r0  <= 1'b0;
         inv_s1   <= 1'b0;
         scale_s1 <= 1'b0;
         next_s1  <= 1'b0;
         next_s2  <= 1'b0;
      end else if (bus.en) begin
         x_r0     <= bus.x_in;
         inv_r0   <= bus.inverse;
         scale_r0 <= bus.scale;
         next_r0  <= bus.next_in;
         inv_s1   <= inv_r0;
         scale_s1 <= scale_r0;
         next_s1  <= next_r0;
         next_s2  <= next_s1;
      end
   end

   genvar gi, li;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_pack
         assign pt_re[gi] = x_r0[cplx_idx(gi, 1'b0, WIDTH) +: WIDTH];
         assign pt_im[gi] = x_r0[cplx_idx(gi, 1'b1, WIDTH) +: WIDTH];
         assign y_pack[cplx_idx(gi, 1'b0, WIDTH) +: WIDTH] = y_re[gi];
         assign y_pack[cplx_idx(gi, 1'b1, WIDTH) +: WIDTH] = y_im[gi];
      end

      for (gi = 0; gi < G; gi++) begin : g_grp
         // S1 lane li: s0 = p0+p2, s1 = p0-p2, s2 = p1+p3, s3 = p1-p3
         for (li = 0; li < 4; li++) begin : g_s1
            localparam int   IA  = gi + (li / 2) * G;
            localparam int   IB  = IA + 2 * G;
            localparam logic SUB = (li % 2) == 1;
            fft_bfly_addsub #(.WIDTH(WIDTH)) u_re (
               .clk(clk), .reset(reset), .en(bus.en), .sub(SUB), .scale(scale_r0),
               .a(pt_re[IA]), .b(pt_re[IB]), .q(s_re[li][gi]));
            fft_bfly_addsub #(.WIDTH(WIDTH)) u_im (
               .clk(clk), .reset(reset), .en(bus.en), .sub(SUB), .scale(scale_r0),
               .a(pt_im[IA]), .b(pt_im[IB]), .q(s_im[li][gi]));
         end

         // y[g] = s0 + s2, y[g+2G] = s0 - s2
         fft_bfly_addsub #(.WIDTH(WIDTH)) u_y0_re (
            .clk(clk), .reset(reset), .en(bus.en), .sub(1'b0), .scale(scale_s1),
            .a(s_re[0][gi]), .b(s_re[2][gi]), .q(y_re[gi]));
         fft_bfly_addsub #(.WIDTH(WIDTH)) u_y0_im (
            .clk(clk), .reset(reset), .en(bus.en), .sub(1'b0), .scale(scale_s1),
            .a(s_im[0][gi]), .b(s_im[2][gi]), .q(y_im[gi]));
         fft_bfly_addsub #(.WIDTH(WIDTH)) u_y2_re (
            .clk(clk), .reset(reset), .en(bus.en), .sub(1'b1), .scale(scale_s1),
            .a(s_re[0][gi]), .b(s_re[2][gi]), .q(y_re[gi+2*G]));
         fft_bfly_addsub #(.WIDTH(WIDTH)) u_y2_im (
            .clk(clk), .reset(reset), .en(bus.en), .sub(1'b1), .scale(scale_s1),
            .a(s_im[0][gi]), .b(s_im[2][gi]), .q(y_im[gi+2*G]));

         // s1 -/+ j*s3: multiplying by j swaps re/im of s3, so the twiddle is
         // just a choice of add vs subtract per lane; inverse flips each choice.
         //   forward y[g+G]  = (s1r + s3i, s1i - s3r)
         //   forward y[g+3G] = (s1r - s3i, s1i + s3r)
         fft_bfly_addsub #(.WIDTH(WIDTH)) u_y1_re (
            .clk(clk), .reset(reset), .en(bus.en), .sub(inv_s1), .scale(scale_s1),
            .a(s_re[1][gi]), .b(s_im[3][gi]), .q(y_re[gi+G]));
         fft_bfly_addsub #(.WIDTH(WIDTH)) u_y1_im (
            .clk(clk), .reset(reset), .en(bus.en), .sub(~inv_s1), .scale(scale_s1),
            .a(s_im[1][gi]), .b(s_re[3][gi]), .q(y_im[gi+G]));
         fft_bfly_addsub #(.WIDTH(WIDTH)) u_y3_re (
            .clk(clk), .reset(reset), .en(bus.en), .sub(~inv_s1), .scale(scale_s1),
            .a(s_re[1][gi]), .b(s_im[3][gi]), .q(y_re[gi+3*G]));
         fft_bfly_addsub #(.WIDTH(WIDTH)) u_y3_im (
            .clk(clk), .reset(reset), .en(bus.en), .sub(inv_s1), .scale(scale_s1),
            .a(s_im[1][gi]), .b(s_re[3][gi]), .q(y_im[gi+3*G]));
      end
   endgenerate

   assign bus.y_out    = y_pack;
   assign bus.next_out = next_s2;

endmodule
